// File: rtl/program_loader_if.sv
// Host byte link, instruction-memory write port and load status for the program loader.
// master = host/bench side, slave = loader.
interface program_loader_if #(
   parameter int ADDR_W = 8
);
   logic [7:0]        byteIn;
   logic              byteValid;
   logic              byteReady;
   logic [ADDR_W-1:0] iWriteAddr;
   logic [15:0]       iWriteData;
   logic              iWriteEn;
   logic              cpuHold;
   logic              done;
   logic              error;

   modport master (
      output byteIn, byteValid,
      input  byteReady, iWriteAddr, iWriteData, iWriteEn, cpuHold, done, error
   );

   modport slave (
      input  byteIn, byteValid,
      output byteReady, iWriteAddr, iWriteData, iWriteEn, cpuHold, done, error
   );
endinterface

// File: rtl/program_loader.sv
// Parses a framed byte stream (header, count, big-endian words, checksum) into
// instruction-memory writes, holding the CPU for the duration of the load.
//
// state | meaning
// IDLE  | discard bytes until HEADER; HEADER clears status and starts a frame
// COUNT | take word count N; N==0 is a framing error
// HI    | take high byte of the next word
// LO    | take low byte, issue the write, count down remaining words
// CHECK | compare byte against running sum, report done or error
module program_loader #(
   parameter logic [7:0] HEADER = 8'hA5,
   parameter int         ADDR_W = 8
) (
   input logic            clk,
   input logic            reset,
   program_loader_if.slave bus
);
   typedef enum logic [2:0] {IDLE, COUNT, HI, LO, CHECK} state_t;

   state_t            state;
   logic [7:0]        words_left;
   logic [7:0]        hi_byte;
   logic [7:0]        csum;
   logic [ADDR_W-1:0] word_addr;
   logic [ADDR_W-1:0] write_addr;
   logic [15:0]       write_data;
   logic              write_en;
   logic              hold;
   logic              done_r;
   logic              error_r;
   logic              accept;

   // Only stall in LO while a write strobe is still out; in practice never hit.
   assign bus.byteReady  = !(state == LO && write_en);
   assign accept         = bus.byteValid && bus.byteReady;

   assign bus.iWriteAddr = write_addr;
   assign bus.iWriteData = write_data;
   assign bus.iWriteEn   = write_en;
   assign bus.cpuHold    = hold;
   assign bus.done       = done_r;
   assign bus.error      = error_r;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         words_left <= '0;
         hi_byte    <= '0;
         csum       <= '0;
         word_addr  <= '0;
         write_addr <= '0;
         write_data <= '0;
         write_en   <= 1'b0;
         hold       <= 1'b0;
         done_r     <= 1'b0;
         error_r    <= 1'b0;
      end else begin
         write_en <= 1'b0;
         if (accept) begin
            case (state)
               IDLE: begin
                  if (bus.byteIn == HEADER) begin
                     done_r     <= 1'b0;
                     error_r    <= 1'b0;
                     words_left <= '0;
                     word_addr  <= '0;
                     csum       <= '0;
                     hold       <= 1'b1;
                     state      <= COUNT;
                  end
               end
               COUNT: begin
                  if (bus.byteIn == 8'd0) begin
                     error_r <= 1'b1;
                     hold    <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     words_left <= bus.byteIn;
                     state      <= HI;
                  end
               end
               HI: begin
                  hi_byte <= bus.byteIn;
                  csum    <= csum + bus.byteIn;
                  state   <= LO;
               end
               LO: begin
                  write_data <= {hi_byte, bus.byteIn};
                  write_addr <= word_addr;
                  write_en   <= 1'b1;
                  word_addr  <= word_addr + ADDR_W'(1);
                  csum       <= csum + bus.byteIn;
                  words_left <= words_left - 8'd1;
                  state      <= (words_left == 8'd1) ? CHECK : HI;
               end
               CHECK: begin
                  if (bus.byteIn == csum) done_r <= 1'b1;
                  else                    error_r <= 1'b1;
                  hold  <= 1'b0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
